// File: rtl/exu_opsel.sv
// ID/EX operand-select stage: forwarding, operand A/B muxing and ALU control encoding,
// held in a two-entry skid buffer so both the ALU side and in_ready are registered.
module exu_opsel #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RIDX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RIDX-1:0] in_rs1_idx,
  input  logic [RIDX-1:0] in_rs2_idx,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel,
  input  logic            in_b_sel,
  input  logic [3:0]      in_alu_op,
  input  logic [RIDX-1:0] in_rd,
  input  logic            in_reg_we,

  input  logic            fwd_we,
  input  logic [RIDX-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_da,
  output logic [XLEN-1:0] alu_db,
  output logic [3:0]      alu_ctl,
  output logic [RIDX-1:0] out_rd,
  output logic            out_reg_we,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic [3:0]      ctl;
    logic [RIDX-1:0] rd;
    logic            reg_we;
    logic            illegal;
  } entry_t;

  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;

  entry_t          in_entry;
  logic [XLEN-1:0] rs1, rs2;
  logic            in_fire;
  logic            drain;

  // Capture-time forwarding and operand/control encoding.
  always_comb begin
    rs1 = in_rs1_val;
    rs2 = in_rs2_val;
    if (fwd_we && (fwd_rd == in_rs1_idx) && (in_rs1_idx != '0)) rs1 = fwd_data;
    if (fwd_we && (fwd_rd == in_rs2_idx) && (in_rs2_idx != '0)) rs2 = fwd_data;

    in_entry.da      = in_a_sel ? in_pc  : rs1;
    in_entry.db      = in_b_sel ? in_imm : rs2;
    in_entry.rd      = in_rd;
    in_entry.illegal = 1'b0;
    case (in_alu_op)
      4'd0:    in_entry.ctl = 4'b0000;
      4'd1:    in_entry.ctl = 4'b0001;
      4'd2:    in_entry.ctl = 4'b0101;
      4'd3:    in_entry.ctl = 4'b1001;
      4'd4:    in_entry.ctl = 4'b1010;
      4'd5:    in_entry.ctl = 4'b1110;
      4'd6:    in_entry.ctl = 4'b0110;
      4'd7:    in_entry.ctl = 4'b0111;
      4'd8:    in_entry.ctl = 4'b1101;
      4'd9:    in_entry.ctl = 4'b1100;
      default: begin
        in_entry.ctl     = 4'b0000;
        in_entry.illegal = 1'b1;
      end
    endcase
    in_entry.reg_we = in_reg_we & ~in_entry.illegal;
  end

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & ~skid_valid_q;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      // Only the valids are cleared; data fields may stay stale.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign alu_da      = main_q.da;
  assign alu_db      = main_q.db;
  assign alu_ctl     = main_q.ctl;
  assign out_rd      = main_q.rd;
  assign out_reg_we  = main_q.reg_we;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_exu_opsel.sv
// Scoreboard bench for exu_opsel: a reference model pushes expected entries on acceptance,
// a monitor pops and compares on every output transfer.
module tb_exu_opsel;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [RIDX-1:0] in_rs1_idx, in_rs2_idx;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
  logic            in_a_sel, in_b_sel;
  logic [3:0]      in_alu_op;
  logic [RIDX-1:0] in_rd;
  logic            in_reg_we;
  logic            fwd_we;
  logic [RIDX-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_da, alu_db;
  logic [3:0]      alu_ctl;
  logic [RIDX-1:0] out_rd;
  logic            out_reg_we;
  logic            out_illegal;

  exu_opsel #(.XLEN(XLEN), .RIDX(RIDX)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_reg_we(in_reg_we),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_da(alu_da), .alu_db(alu_db), .alu_ctl(alu_ctl),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic [3:0]      ctl;
    logic [RIDX-1:0] rd;
    logic            we;
    logic            ill;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  logic [3:0] ctl_tab [10] = '{4'b0000, 4'b0001, 4'b0101, 4'b1001, 4'b1010,
                               4'b1110, 4'b0110, 4'b0111, 4'b1101, 4'b1100};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] src(input logic [RIDX-1:0] idx, input logic [XLEN-1:0] v);
    return (fwd_we && idx != 0 && fwd_rd == idx) ? fwd_data : v;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.da  = in_a_sel ? in_pc  : src(in_rs1_idx, in_rs1_val);
    e.db  = in_b_sel ? in_imm : src(in_rs2_idx, in_rs2_val);
    e.rd  = in_rd;
    e.ill = (in_alu_op >= 4'd10);
    e.ctl = e.ill ? 4'b0000 : ctl_tab[in_alu_op];
    e.we  = in_reg_we && !e.ill;
    return e;
  endfunction

  // Monitor / scoreboard
  logic            hold = 1'b0;
  logic [XLEN-1:0] p_da, p_db;
  logic [3:0]      p_ctl;
  logic [RIDX-1:0] p_rd;
  logic            p_we, p_ill;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_da", alu_da, p_da);
        check("stall_db", alu_db, p_db);
        check("stall_ctl", alu_ctl, p_ctl);
        check("stall_rd", out_rd, p_rd);
        check("stall_we", out_reg_we, p_we);
        check("stall_ill", out_illegal, p_ill);
      end
      check("out_valid_occ", out_valid, q.size() != 0);
      check("in_ready_occ", in_ready, q.size() < 2);
      if (out_valid && out_ready) begin
        check("out_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("alu_da", alu_da, e.da);
          check("alu_db", alu_db, e.db);
          check("alu_ctl", alu_ctl, e.ctl);
          check("out_rd", out_rd, e.rd);
          check("out_reg_we", out_reg_we, e.we);
          check("out_illegal", out_illegal, e.ill);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model());
      hold  = out_valid && !out_ready && !flush;
      p_da  = alu_da;
      p_db  = alu_db;
      p_ctl = alu_ctl;
      p_rd  = out_rd;
      p_we  = out_reg_we;
      p_ill = out_illegal;
    end
  end

  task automatic idle_in();
    in_valid = 0; flush = 0; in_pc = '0; in_rs1_idx = '0; in_rs2_idx = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_a_sel = 0; in_b_sel = 0;
    in_alu_op = '0; in_rd = '0; in_reg_we = 0; fwd_we = 0; fwd_rd = '0; fwd_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain op: da = rs1_val (idx 1, no forwarding), db = imm.
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    in_valid = 1; in_rs1_idx = 5'd1; in_rs1_val = a; in_a_sel = 0;
    in_b_sel = 1; in_imm = b; in_alu_op = op; in_rd = 5'd7; in_reg_we = 1; fwd_we = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_da"}, alu_da, 0);
    check({tag, "_db"}, alu_db, 0);
    check({tag, "_ctl"}, alu_ctl, 0);
    check({tag, "_rd"}, out_rd, 0);
    check({tag, "_we"}, out_reg_we, 0);
    check({tag, "_ill"}, out_illegal, 0);
  endtask

  initial begin
    idle_in();
    out_ready = 0;
    rst_n = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1;
    tick();

    // Test 1: ADD, rs1 = 5, imm = 7
    out_ready = 1;
    set_op(32'd5, 32'd7, 4'd0);
    tick();
    in_valid = 0;
    check("t1_valid", out_valid, 1);
    check("t1_da", alu_da, 32'd5);
    check("t1_db", alu_db, 32'd7);
    check("t1_ctl", alu_ctl, 4'b0000);
    tick();

    // Test 2: forwarding hit, then idx 0 never forwards
    set_op(32'h11, 32'd1, 4'd0);
    in_rs1_idx = 5'd3; fwd_we = 1; fwd_rd = 5'd3; fwd_data = 32'hDEAD;
    tick();
    in_valid = 0; fwd_we = 0;
    check("t2_fwd_da", alu_da, 32'hDEAD);
    set_op(32'h11, 32'd1, 4'd0);
    in_rs1_idx = 5'd0; fwd_we = 1; fwd_rd = 5'd0; fwd_data = 32'hDEAD;
    tick();
    in_valid = 0; fwd_we = 0;
    check("t2_x0_da", alu_da, 32'h11);
    tick();

    // Test 3: back-pressure with A, B, C
    out_ready = 0;
    set_op(32'hA, 32'd0, 4'd0);
    tick();
    check("t3_ready_after_a", in_ready, 1);
    set_op(32'hB, 32'd0, 4'd0);
    tick();
    check("t3_ready_after_b", in_ready, 0);
    set_op(32'hC, 32'd0, 4'd0);
    tick(); tick();
    check("t3_stall_da", alu_da, 32'hA);
    out_ready = 1;
    @(negedge clk);
    check("t3_first", alu_da, 32'hA);
    check("t3_first_v", out_valid, 1);
    @(negedge clk);
    check("t3_second", alu_da, 32'hB);
    check("t3_second_v", out_valid, 1);
    check("t3_ready_back", in_ready, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("t3_third", alu_da, 32'hC);
    check("t3_third_v", out_valid, 1);
    tick();

    // Test 4: flush with main + skid full and a same-cycle input
    out_ready = 0;
    set_op(32'h100, 32'd0, 4'd1);
    tick();
    set_op(32'h200, 32'd0, 4'd1);
    tick();
    set_op(32'h300, 32'd0, 4'd1);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    check("t4_valid", out_valid, 0);
    check("t4_ready", in_ready, 1);
    out_ready = 1;
    repeat (4) tick();
    check("t4_still_empty", out_valid, 0);

    // Test 5: op sweep
    for (int op = 0; op < 16; op++) begin
      set_op(32'(op) + 32'h40, 32'd3, 4'(op));
      tick();
    end
    in_valid = 0;
    tick(); tick();

    // Test 6: asynchronous reset with both entries buffered
    out_ready = 0;
    set_op(32'h55, 32'h66, 4'd5);
    tick();
    set_op(32'h77, 32'h88, 4'd8);
    tick();
    in_valid = 0;
    check("t6_full", in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("t6");
    @(posedge clk); #1; rst_n = 1;
    tick();

    // Random phase
    for (int i = 0; i < 800; i++) begin
      in_valid   = ($urandom % 4) != 0;
      in_pc      = $urandom;
      in_rs1_idx = 5'($urandom % 4);
      in_rs2_idx = 5'($urandom % 4);
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      in_imm     = $urandom;
      in_a_sel   = 1'($urandom);
      in_b_sel   = 1'($urandom);
      in_alu_op  = 4'($urandom);
      in_rd      = 5'($urandom);
      in_reg_we  = 1'($urandom);
      fwd_we     = 1'($urandom);
      fwd_rd     = 5'($urandom % 4);
      fwd_data   = $urandom;
      out_ready  = ($urandom % 3) != 0;
      flush      = ($urandom % 25) == 0;
      tick();
    end
    idle_in();
    out_ready = 1;
    repeat (4) tick();
    @(negedge clk);
    check("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
